// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   Final stage of the Y86-64 pipeline. It holds the W pipeline register,
//   owns the 15-entry architectural register file (two write ports, two
//   combinational read ports for decode), and reports processor status,
//   a sticky halt flag and a retired-instruction count.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   m_stat..m_dstM      memory-stage results captured into W
//   W_stall, W_bubble   W register hold / bubble-insert controls (stall wins)
//   srcA, srcB          decode read port register ids (0xF reads 0)
//   d_rvalA, d_rvalB    register file read data (no same-cycle bypass)
//   W_stat..W_dstM      W register contents (forwarding sources for decode)
//   stat                processor status
//   halted              sticky stop flag, cleared only by rst
//   retired             count of retired non-bubble instructions
// ---------------------------------------------------------------------------
module writeback_stage #(
   parameter int                 DATA_W   = 64,
   parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        m_stat,
   input  logic [3:0]        m_icode,
   input  logic [DATA_W-1:0] m_valE,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [3:0]        m_dstE,
   input  logic [3:0]        m_dstM,
   input  logic              W_stall,
   input  logic              W_bubble,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] d_rvalA,
   output logic [DATA_W-1:0] d_rvalB,
   output logic [2:0]        W_stat,
   output logic [3:0]        W_icode,
   output logic [DATA_W-1:0] W_valE,
   output logic [DATA_W-1:0] W_valM,
   output logic [3:0]        W_dstE,
   output logic [3:0]        W_dstM,
   output logic [2:0]        stat,
   output logic              halted,
   output logic [63:0]       retired
);

   localparam logic [2:0] SAOK  = 3'd1;
   localparam logic [2:0] SHLT  = 3'd2;
   localparam logic [3:0] I_NOP = 4'h1;
   localparam logic [3:0] RNONE = 4'hF;

   // ---------------- W pipeline register ----------------
   logic [2:0]        w_stat_q,  w_stat_d;
   logic [3:0]        w_icode_q, w_icode_d;
   logic [DATA_W-1:0] w_vale_q,  w_vale_d;
   logic [DATA_W-1:0] w_valm_q,  w_valm_d;
   logic [3:0]        w_dste_q,  w_dste_d;
   logic [3:0]        w_dstm_q,  w_dstm_d;
   logic              halted_q,  halted_d;
   logic [63:0]       retired_q, retired_d;

   always_comb begin
      w_stat_d  = w_stat_q;
      w_icode_d = w_icode_q;
      w_vale_d  = w_vale_q;
      w_valm_d  = w_valm_q;
      w_dste_d  = w_dste_q;
      w_dstm_d  = w_dstm_q;
      // Stall takes priority over bubble; a halted machine freezes W.
      if (!halted_q && !W_stall) begin
         if (W_bubble) begin
            w_stat_d  = SAOK;
            w_icode_d = I_NOP;
            w_vale_d  = '0;
            w_valm_d  = '0;
            w_dste_d  = RNONE;
            w_dstm_d  = RNONE;
         end else begin
            w_stat_d  = m_stat;
            w_icode_d = m_icode;
            w_vale_d  = m_valE;
            w_valm_d  = m_valM;
            w_dste_d  = m_dstE;
            w_dstm_d  = m_dstM;
         end
      end
   end

   // Any non-AOK status reaching W stops the machine for good.
   always_comb begin
      halted_d  = halted_q | (w_stat_q != SAOK);
      retired_d = retired_q;
      // An instruction is counted on the edge it leaves W, so a held one
      // is not counted while stalled. SHLT counts; faulting ones do not.
      if (!halted_q && !W_stall && (w_icode_q != I_NOP) &&
          ((w_stat_q == SAOK) || (w_stat_q == SHLT)))
         retired_d = retired_q + 64'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_stat_q  <= SAOK;
         w_icode_q <= I_NOP;
         w_vale_q  <= '0;
         w_valm_q  <= '0;
         w_dste_q  <= RNONE;
         w_dstm_q  <= RNONE;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         w_stat_q  <= w_stat_d;
         w_icode_q <= w_icode_d;
         w_vale_q  <= w_vale_d;
         w_valm_q  <= w_valm_d;
         w_dste_q  <= w_dste_d;
         w_dstm_q  <= w_dstm_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   // ---------------- Register file ----------------
   logic              we_e, we_m;
   logic [DATA_W-1:0] rf_view [15];

   assign we_e = !halted_q && (w_stat_q == SAOK) && (w_dste_q != RNONE);
   assign we_m = !halted_q && (w_stat_q == SAOK) && (w_dstm_q != RNONE);

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_rf
         localparam logic [3:0]        ID      = 4'(gi);
         localparam logic [DATA_W-1:0] RST_VAL = (gi == 4) ? RSP_INIT : '0;
         logic [DATA_W-1:0] r_q, r_d;

         // valM port is applied last so it wins when both target this entry.
         always_comb begin
            r_d = r_q;
            if (we_e && (w_dste_q == ID)) r_d = w_vale_q;
            if (we_m && (w_dstm_q == ID)) r_d = w_valm_q;
         end

         always_ff @(posedge clk) begin
            if (rst) r_q <= RST_VAL;
            else     r_q <= r_d;
         end

         assign rf_view[gi] = r_q;
      end
   endgenerate

   // Reads see array state only; RNONE (0xF) matches no entry and reads 0.
   always_comb begin
      d_rvalA = '0;
      d_rvalB = '0;
      for (int i = 0; i < 15; i++) begin
         if (srcA == 4'(i)) d_rvalA = rf_view[i];
         if (srcB == 4'(i)) d_rvalB = rf_view[i];
      end
   end

   // ---------------- Outputs ----------------
   assign W_stat  = w_stat_q;
   assign W_icode = w_icode_q;
   assign W_valE  = w_vale_q;
   assign W_valM  = w_valm_q;
   assign W_dstE  = w_dste_q;
   assign W_dstM  = w_dstm_q;
   assign stat    = w_stat_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//   Directed bench: a table of single-cycle vectors for the normal
//   write/forward path, then hand-written sequences for stall/bubble,
//   exception halt, SHLT halt and reset while halted.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

   localparam logic [63:0] RSP0 = 64'h1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  m_stat;
   logic [3:0]  m_icode;
   logic [63:0] m_valE, m_valM;
   logic [3:0]  m_dstE, m_dstM;
   logic        W_stall, W_bubble;
   logic [3:0]  srcA, srcB;
   logic [63:0] d_rvalA, d_rvalB;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  W_dstE, W_dstM;
   logic [2:0]  stat;
   logic        halted;
   logic [63:0] retired;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   writeback_stage #(.DATA_W(64), .RSP_INIT(RSP0)) dut (
      .clk(clk), .rst(rst),
      .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
      .m_dstE(m_dstE), .m_dstM(m_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble),
      .srcA(srcA), .srcB(srcB),
      .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
      .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM),
      .stat(stat), .halted(halted), .retired(retired)
   );

   typedef struct {
      logic [2:0]  st;
      logic [3:0]  ic;
      logic [63:0] ve, vm;
      logic [3:0]  de, dm, sa, sb;
      logic [3:0]  x_ic;
      logic [63:0] x_ve;
      logic [3:0]  x_de;
      logic [63:0] x_ra, x_rb, x_ret;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input logic [2:0] st, input logic [3:0] ic,
                               input logic [63:0] ve, input logic [63:0] vm,
                               input logic [3:0] de, input logic [3:0] dm,
                               input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] x_ic, input logic [63:0] x_ve,
                               input logic [3:0] x_de, input logic [63:0] x_ra,
                               input logic [63:0] x_rb, input logic [63:0] x_ret);
      vec_t v;
      v.st = st; v.ic = ic; v.ve = ve; v.vm = vm; v.de = de; v.dm = dm;
      v.sa = sa; v.sb = sb; v.x_ic = x_ic; v.x_ve = x_ve; v.x_de = x_de;
      v.x_ra = x_ra; v.x_rb = x_rb; v.x_ret = x_ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm);
      m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
   endtask

   task automatic read_a(input string name, input logic [3:0] r, input logic [63:0] exp);
      srcA = r;
      #1;
      chk(name, d_rvalA, exp);
   endtask

   task automatic check_reset_state(input string tag);
      for (int r = 0; r < 15; r++)
         read_a($sformatf("%s_reg%0d", tag, r), 4'(r), (r == 4) ? RSP0 : 64'd0);
      read_a({tag, "_rnone"}, 4'hF, 64'd0);
      chk({tag, "_stat"},    64'(stat),    64'd1);
      chk({tag, "_halted"},  64'(halted),  64'd0);
      chk({tag, "_retired"}, retired,      64'd0);
      chk({tag, "_W_icode"}, 64'(W_icode), 64'd1);
      chk({tag, "_W_dstE"},  64'(W_dstE),  64'hF);
      chk({tag, "_W_dstM"},  64'(W_dstM),  64'hF);
   endtask

   initial begin
      // Inputs applied before an edge; expectations checked 1 time unit after it.
      vecs[0] = mk(1, 3, 64'h1234, 0,      2, 4'hF, 2, 4,   3, 64'h1234, 2,    0,       RSP0,    0);
      vecs[1] = mk(1, 1, 0,        0,      4'hF, 4'hF, 2, 3, 1, 0,        4'hF, 64'h1234, 0,      1);
      vecs[2] = mk(1, 4'hB, 64'h108, 64'h55, 4, 4,  4, 2,   4'hB, 64'h108, 4,   RSP0,    64'h1234, 1);
      vecs[3] = mk(1, 3, 64'h77,   0,      6, 4'hF, 4, 6,   3, 64'h77,   6,    64'h55,  0,       2);
      vecs[4] = mk(1, 5, 64'hAAAA, 64'hBEEF, 4'hF, 7, 6, 7, 5, 64'hAAAA, 4'hF, 64'h77,  0,       3);
      vecs[5] = mk(1, 1, 0,        0,      4'hF, 4'hF, 7, 4'hF, 1, 0,      4'hF, 64'hBEEF, 0,      4);
      vecs[6] = mk(1, 4'hB, 64'h200, 64'h99, 4, 8,  4, 8,   4'hB, 64'h200, 4,   64'h55,  0,       4);
      vecs[7] = mk(1, 1, 0,        0,      4'hF, 4'hF, 4, 8, 1, 0,        4'hF, 64'h200, 64'h99,  5);

      rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'h0; srcB = 4'h0;
      drive(1, 1, 0, 0, 4'hF, 4'hF);
      tick(); tick();
      check_reset_state("rst0");
      rst = 1'b0;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].st, vecs[i].ic, vecs[i].ve, vecs[i].vm, vecs[i].de, vecs[i].dm);
         srcA = vecs[i].sa; srcB = vecs[i].sb;
         tick();
         chk($sformatf("v%0d_W_icode", i), 64'(W_icode), 64'(vecs[i].x_ic));
         chk($sformatf("v%0d_W_valE", i),  W_valE,       vecs[i].x_ve);
         chk($sformatf("v%0d_W_dstE", i),  64'(W_dstE),  64'(vecs[i].x_de));
         chk($sformatf("v%0d_rvalA", i),   d_rvalA,      vecs[i].x_ra);
         chk($sformatf("v%0d_rvalB", i),   d_rvalB,      vecs[i].x_rb);
         chk($sformatf("v%0d_retired", i), retired,      vecs[i].x_ret);
         chk($sformatf("v%0d_stat", i),    64'(stat),    64'd1);
         chk($sformatf("v%0d_halted", i),  64'(halted),  64'd0);
      end

      // ---------------- stall, then bubble ----------------
      drive(1, 3, 64'h3333, 0, 9, 4'hF);
      tick();
      chk("ld_W_valE", W_valE, 64'h3333);
      for (int k = 0; k < 3; k++) begin
         W_stall  = 1'b1;
         W_bubble = (k == 2);            // stall must beat bubble
         drive(1, 4'(6 + k), 64'(k + 64'h9000), 64'h1, 10, 11);
         tick();
         chk($sformatf("stall%0d_W_icode", k), 64'(W_icode), 64'd3);
         chk($sformatf("stall%0d_W_valE", k),  W_valE,       64'h3333);
         chk($sformatf("stall%0d_W_dstE", k),  64'(W_dstE),  64'd9);
         chk($sformatf("stall%0d_retired", k), retired,      64'd5);
      end
      W_stall = 1'b0; W_bubble = 1'b1;
      tick();
      chk("bub_W_icode", 64'(W_icode), 64'd1);
      chk("bub_W_dstE",  64'(W_dstE),  64'hF);
      chk("bub_retired", retired,      64'd6);    // held insn counted as it leaves
      tick();
      chk("bub2_retired", retired, 64'd6);
      read_a("bub_reg9",  4'd9,  64'h3333);
      read_a("bub_reg10", 4'd10, 64'd0);
      read_a("bub_reg11", 4'd11, 64'd0);
      W_bubble = 1'b0;

      // ---------------- SADR exception halt ----------------
      srcA = 4'd5;
      drive(3, 5, 64'h5555, 0, 5, 4'hF);
      tick();
      chk("adr_stat",    64'(stat),   64'd3);
      chk("adr_halted0", 64'(halted), 64'd0);
      tick();
      chk("adr_halted1", 64'(halted), 64'd1);
      chk("adr_reg5",    d_rvalA,     64'd0);
      chk("adr_retired", retired,     64'd6);
      drive(1, 3, 64'h9, 0, 5, 4'hF);
      tick(); tick();
      chk("adr_frz_icode", 64'(W_icode), 64'd5);
      chk("adr_frz_stat",  64'(stat),    64'd3);
      chk("adr_frz_reg5",  d_rvalA,      64'd0);
      chk("adr_frz_ret",   retired,      64'd6);
      chk("adr_frz_halt",  64'(halted),  64'd1);

      rst = 1'b1;
      tick();
      check_reset_state("rst1");
      rst = 1'b0;

      // ---------------- SHLT halt, valid write caught in W ----------------
      drive(2, 0, 0, 0, 4'hF, 4'hF);
      tick();
      chk("hlt_stat",    64'(stat),    64'd2);
      chk("hlt_icode",   64'(W_icode), 64'd0);
      chk("hlt_retired", retired,      64'd0);
      drive(1, 3, 64'hCAFE, 0, 11, 4'hF);
      tick();
      chk("hlt_halted",   64'(halted),  64'd1);
      chk("hlt_retired1", retired,      64'd1);
      chk("hlt_W_valE",   W_valE,       64'hCAFE);
      drive(1, 6, 64'hDEAD, 0, 12, 4'hF);
      tick();
      chk("hlt_frz_valE", W_valE,  64'hCAFE);
      chk("hlt_frz_ret",  retired, 64'd1);
      read_a("hlt_reg11", 4'd11, 64'd0);

      // ---------------- reset while halted with pending write ----------------
      rst = 1'b1;
      tick();
      check_reset_state("rst2");
      rst = 1'b0;
      drive(1, 1, 0, 0, 4'hF, 4'hF);
      tick();
      read_a("post_reg11", 4'd11, 64'd0);
      chk("post_retired", retired, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
